// File: rtl/multi_dataflow_ctrl_fsm_pkg.sv
// State encoding and control/status bundles for the multi-stream dataflow FSM.
// Bundle fields are sized for the largest supported configuration.
package multi_dataflow_package;

   localparam int unsigned MAX_STREAMS  = 16;
   localparam int unsigned MAX_ADDR_W   = 64;
   localparam int unsigned MAX_STRIDE_W = 32;
   localparam int unsigned MAX_ITER_W   = 32;

   typedef enum logic [2:0] {
      IDLE,
      START,
      COMPUTE,
      WAIT,
      UPDATEIDX,
      TERMINATE
   } state_fsm_t;

   typedef struct packed {
      logic [MAX_ITER_W-1:0]                     nb_iter;
      logic [MAX_STREAMS-1:0][MAX_ADDR_W-1:0]    base;
      logic [MAX_STREAMS-1:0][MAX_STRIDE_W-1:0]  stride;
   } ctrl_dataflow_fsm_t;

   typedef struct packed {
      logic                  busy;
      logic                  done;
      logic                  err;
      logic [MAX_ITER_W-1:0] iter_idx;
   } flags_dataflow_fsm_t;

   // A tile count of zero still runs one tile.
   function automatic logic [MAX_ITER_W-1:0] eff_iter(
      input logic [MAX_ITER_W-1:0] n
   );
      return (n == '0) ? MAX_ITER_W'(1) : n;
   endfunction

endpackage

// File: rtl/multi_dataflow_addr_upd.sv
// One stream address register: clear, load from base, or step by the tile stride.
// The step wraps modulo 2^ADDR_WIDTH; the stride is zero-extended.
module multi_dataflow_addr_upd #(
   parameter int unsigned ADDR_WIDTH   = 32,
   parameter int unsigned STRIDE_WIDTH = 16
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    clear,
   input  logic                    load,
   input  logic                    step,
   input  logic [ADDR_WIDTH-1:0]   base,
   input  logic [STRIDE_WIDTH-1:0] stride,
   output logic [ADDR_WIDTH-1:0]   addr
);

   logic [ADDR_WIDTH-1:0] addr_d;

   always_comb begin
      addr_d = addr;
      unique case (1'b1)
         clear:   addr_d = '0;
         load:    addr_d = base;
         step:    addr_d = addr + ADDR_WIDTH'(stride);
         default: addr_d = addr;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) addr <= '0;
      else        addr <= addr_d;
   end

endmodule

// File: rtl/multi_dataflow_ctrl_fsm.sv
// Multi-stream, multi-tile HWPE dataflow control FSM.
// Optional watchdog: define HWPE_DATAFLOW_FSM_WATCHDOG_EN.
module multi_dataflow_ctrl_fsm
   import multi_dataflow_package::*;
#(
   parameter int unsigned N_IN           = 3,
   parameter int unsigned N_OUT          = 1,
   parameter int unsigned ADDR_WIDTH     = 32,
   parameter int unsigned STRIDE_WIDTH   = 16,
   parameter int unsigned ITER_WIDTH     = 16,
   parameter int unsigned TIMEOUT_CYCLES = 4096
) (
   input  logic                                    clk_i,
   input  logic                                    rst_ni,
   input  logic                                    clear_i,
   input  logic                                    start_i,
   input  logic [ITER_WIDTH-1:0]                   nb_iter_i,
   input  logic [(N_IN+N_OUT)*ADDR_WIDTH-1:0]      base_addr_i,
   input  logic [(N_IN+N_OUT)*STRIDE_WIDTH-1:0]    tile_stride_i,
   output logic [N_IN-1:0]                         src_req_o,
   output logic [N_OUT-1:0]                        sink_req_o,
   output logic [(N_IN+N_OUT)*ADDR_WIDTH-1:0]      stream_addr_o,
   input  logic [N_IN-1:0]                         src_done_i,
   input  logic [N_OUT-1:0]                        sink_done_i,
   output logic                                    engine_start_o,
   input  logic                                    engine_done_i,
   output logic [ITER_WIDTH-1:0]                   iter_idx_o,
   output logic                                    busy_o,
   output logic                                    done_o,
   output logic                                    err_o
);

   localparam int unsigned NS = N_IN + N_OUT;

   state_fsm_t            state_q, state_d;
   ctrl_dataflow_fsm_t    ctrl;
   flags_dataflow_fsm_t   flags;

   logic [MAX_ITER_W-1:0] nb_iter_q;
   logic [MAX_ITER_W-1:0] iter_q;
   logic [N_IN-1:0]       src_flag;
   logic [N_OUT-1:0]      sink_flag;
   logic                  eng_flag;
   logic                  load;
   logic                  step;
   logic                  last;
   logic                  comp_ok;
   logic                  sink_ok;
   logic                  timeout;
   logic                  err;
   logic                  unused_bits;

   always_comb begin
      ctrl = '0;
      ctrl.nb_iter[ITER_WIDTH-1:0] = nb_iter_i;
      for (int i = 0; i < NS; i++) begin
         ctrl.base[i][ADDR_WIDTH-1:0] =
            base_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
         ctrl.stride[i][STRIDE_WIDTH-1:0] =
            tile_stride_i[i*STRIDE_WIDTH +: STRIDE_WIDTH];
      end
   end

   assign load = (state_q == IDLE) && start_i && !clear_i;
   assign step = (state_q == UPDATEIDX) && !clear_i;
   assign last = ((iter_q + MAX_ITER_W'(1)) == nb_iter_q);

   // A done pulse counts in the same cycle it arrives.
   assign comp_ok = (&(src_flag | src_done_i)) && (eng_flag || engine_done_i);
   assign sink_ok = &(sink_flag | sink_done_i);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) state_q <= IDLE;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (clear_i) begin
         state_d = IDLE;
      end else begin
         unique case (state_q)
            IDLE:      if (start_i) state_d = START;
            START:     state_d = COMPUTE;
            COMPUTE: begin
               if (timeout)      state_d = TERMINATE;
               else if (comp_ok) state_d = WAIT;
            end
            WAIT: begin
               if (timeout)      state_d = TERMINATE;
               else if (sink_ok) state_d = UPDATEIDX;
            end
            UPDATEIDX: state_d = last ? TERMINATE : START;
            TERMINATE: state_d = IDLE;
            default:   state_d = IDLE;
         endcase
      end
   end

   // Completion flags are sticky within a tile and reset at each START.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         src_flag  <= '0;
         sink_flag <= '0;
         eng_flag  <= 1'b0;
      end else if (clear_i || state_q == START) begin
         src_flag  <= '0;
         sink_flag <= '0;
         eng_flag  <= 1'b0;
      end else if (state_q == COMPUTE) begin
         src_flag  <= src_flag | src_done_i;
         sink_flag <= sink_flag | sink_done_i;
         eng_flag  <= eng_flag | engine_done_i;
      end else if (state_q == WAIT) begin
         sink_flag <= sink_flag | sink_done_i;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         iter_q    <= '0;
         nb_iter_q <= '0;
      end else if (clear_i) begin
         iter_q    <= '0;
         nb_iter_q <= '0;
      end else if (load) begin
         iter_q    <= '0;
         nb_iter_q <= eff_iter(ctrl.nb_iter);
      end else if (step && !last) begin
         iter_q    <= iter_q + MAX_ITER_W'(1);
      end
   end

`ifdef HWPE_DATAFLOW_FSM_WATCHDOG_EN
   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [CNT_W-1:0] wd_cnt;
   logic             err_q;
   logic             active;

   assign active  = (state_q == COMPUTE) || (state_q == WAIT);
   assign timeout = active && (wd_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
   assign err     = err_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)                            wd_cnt <= '0;
      else if (clear_i || state_q == START)   wd_cnt <= '0;
      else if (active)                        wd_cnt <= wd_cnt + CNT_W'(1);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)                err_q <= 1'b0;
      else if (clear_i || load)   err_q <= 1'b0;
      else if (timeout)           err_q <= 1'b1;
   end
`else
   localparam int unsigned unused_timeout = TIMEOUT_CYCLES;

   assign timeout = 1'b0;
   assign err     = 1'b0;
`endif

   always_comb begin
      flags          = '0;
      flags.busy     = (state_q != IDLE);
      flags.done     = (state_q == TERMINATE);
      flags.err      = err;
      flags.iter_idx = iter_q;
      src_req_o      = '0;
      sink_req_o     = '0;
      engine_start_o = 1'b0;
      if (state_q == START) begin
         src_req_o      = '1;
         sink_req_o     = '1;
         engine_start_o = 1'b1;
      end
   end

   assign busy_o      = flags.busy;
   assign done_o      = flags.done;
   assign err_o       = flags.err;
   assign iter_idx_o  = flags.iter_idx[ITER_WIDTH-1:0];
   assign unused_bits = ^{ctrl, flags};

   for (genvar g = 0; g < NS; g++) begin : g_stream
      multi_dataflow_addr_upd #(
         .ADDR_WIDTH   (ADDR_WIDTH),
         .STRIDE_WIDTH (STRIDE_WIDTH)
      ) i_addr_upd (
         .clk    (clk_i),
         .rst_n  (rst_ni),
         .clear  (clear_i),
         .load   (load),
         .step   (step),
         .base   (ctrl.base[g][ADDR_WIDTH-1:0]),
         .stride (ctrl.stride[g][STRIDE_WIDTH-1:0]),
         .addr   (stream_addr_o[g*ADDR_WIDTH +: ADDR_WIDTH])
      );
   end

endmodule

// File: tb/tb_multi_dataflow_ctrl_fsm.sv
// Bench for multi_dataflow_ctrl_fsm: per-job cycle timeline predicted from
// done-pulse arrival times, addresses from base + k*stride arithmetic.
module tb_multi_dataflow_ctrl_fsm;

   localparam int NI   = 3;
   localparam int NO   = 1;
   localparam int NS   = NI + NO;
   localparam int AW   = 32;
   localparam int SW   = 16;
   localparam int IW   = 16;
   localparam int MAXC = 256;
   localparam logic [63:0] REQ_ALL = (64'd1 << (NS + 1)) - 64'd1;

   logic              clk;
   logic              rst_n;
   logic              clear_i;
   logic              start_i;
   logic [IW-1:0]     nb_iter_i;
   logic [NS*AW-1:0]  base_addr_i;
   logic [NS*SW-1:0]  tile_stride_i;
   logic [NI-1:0]     src_req_o;
   logic [NO-1:0]     sink_req_o;
   logic [NS*AW-1:0]  stream_addr_o;
   logic [NI-1:0]     src_done_i;
   logic [NO-1:0]     sink_done_i;
   logic              engine_start_o;
   logic              engine_done_i;
   logic [IW-1:0]     iter_idx_o;
   logic              busy_o;
   logic              done_o;
   logic              err_o;

   multi_dataflow_ctrl_fsm #(
      .N_IN (NI), .N_OUT (NO), .ADDR_WIDTH (AW),
      .STRIDE_WIDTH (SW), .ITER_WIDTH (IW), .TIMEOUT_CYCLES (4096)
   ) dut (
      .clk_i          (clk),
      .rst_ni         (rst_n),
      .clear_i        (clear_i),
      .start_i        (start_i),
      .nb_iter_i      (nb_iter_i),
      .base_addr_i    (base_addr_i),
      .tile_stride_i  (tile_stride_i),
      .src_req_o      (src_req_o),
      .sink_req_o     (sink_req_o),
      .stream_addr_o  (stream_addr_o),
      .src_done_i     (src_done_i),
      .sink_done_i    (sink_done_i),
      .engine_start_o (engine_start_o),
      .engine_done_i  (engine_done_i),
      .iter_idx_o     (iter_idx_o),
      .busy_o         (busy_o),
      .done_o         (done_o),
      .err_o          (err_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   logic [AW-1:0] bases[NS];
   logic [SW-1:0] strides[NS];

   bit            e_req[MAXC];
   bit            e_done[MAXC];
   bit            e_busy[MAXC];
   int            e_tile[MAXC];
   logic [NI-1:0] p_src[MAXC];
   logic [NO-1:0] p_sink[MAXC];
   bit            p_eng[MAXC];
   bit            p_clr[MAXC];

   function automatic logic [AW-1:0] model_addr(input int i, input int k);
      return bases[i] + AW'(k) * AW'(strides[i]);
   endfunction

   function automatic logic [AW-1:0] dut_addr(input int i);
      return stream_addr_o[i*AW +: AW];
   endfunction

   // mode 0: random done offsets, 1: all dones in first COMPUTE cycle,
   // 2: sink done before engine done
   task automatic run_job(input int nb, input int mode,
                          input int clear_tile, input bit hang);
      int eff, t, upd, a, s, off, term, len, clear_cyc;
      for (int c = 0; c < MAXC; c++) begin
         e_req[c] = 0; e_done[c] = 0; e_busy[c] = 0; e_tile[c] = -1;
         p_src[c] = '0; p_sink[c] = '0; p_eng[c] = 0; p_clr[c] = 0;
      end
      for (int i = 0; i < NS; i++) begin
         base_addr_i[i*AW +: AW]   = bases[i];
         tile_stride_i[i*SW +: SW] = strides[i];
      end
      nb_iter_i = IW'(nb);
      eff = (nb == 0) ? 1 : nb;
      t = 1;
      clear_cyc = -1;
      for (int k = 0; k < eff; k++) begin
         e_req[t] = 1; e_tile[t] = k; a = 0; s = 0;
         for (int j = 0; j < NI; j++) begin
            off = (mode == 1) ? 0 : (mode == 2) ? 1 : int'($urandom_range(0, 4));
            p_src[t+1+off][j] = 1'b1;
            if (off > a) a = off;
         end
         off = (mode == 1) ? 0 : (mode == 2) ? 3 : int'($urandom_range(0, 4));
         p_eng[t+1+off] = 1;
         if (off > a) a = off;
         for (int j = 0; j < NO; j++) begin
            off = (mode == 0) ? int'($urandom_range(0, 6)) : 0;
            p_sink[t+1+off][j] = 1'b1;
            if (off > s) s = off;
         end
         if (k == clear_tile) clear_cyc = t + 1;
         // WAIT entered the cycle after the last source/engine done;
         // it exits once the last sink done has been seen.
         upd = ((t + 2 + a) > (t + 1 + s)) ? (t + 2 + a) : (t + 1 + s);
         upd = upd + 1;
         for (int c = t; c <= upd; c++) e_busy[c] = 1;
         t = upd + 1;
      end
      term = t;
      e_done[term] = 1;
      e_busy[term] = 1;
      len = term + 3;
      if (hang) begin
         clear_cyc = 40;
         for (int c = 2; c < MAXC; c++) begin
            e_req[c] = 0; e_done[c] = 0; e_tile[c] = -1;
            e_busy[c] = (c <= 40); p_eng[c] = 0;
         end
      end
      if (clear_cyc >= 0) begin
         for (int c = clear_cyc; c < MAXC; c++) begin
            p_src[c] = '0; p_sink[c] = '0; p_eng[c] = 0;
            if (c > clear_cyc) begin
               e_req[c] = 0; e_done[c] = 0; e_busy[c] = 0; e_tile[c] = -1;
            end
         end
         p_clr[clear_cyc] = 1;
         len = clear_cyc + 4;
      end
      for (int c = 0; c < len; c++) begin
         start_i       = (c == 0);
         clear_i       = p_clr[c];
         src_done_i    = p_src[c];
         sink_done_i   = p_sink[c];
         engine_done_i = p_eng[c];
         check("req", 64'({src_req_o, sink_req_o, engine_start_o}),
               e_req[c] ? REQ_ALL : 64'd0);
         check("done", 64'(done_o), 64'(e_done[c]));
         check("busy", 64'(busy_o), 64'(e_busy[c]));
         check("err", 64'(err_o), 64'd0);
         if (e_tile[c] >= 0) begin
            check("iter_start", 64'(iter_idx_o), 64'(e_tile[c]));
            for (int i = 0; i < NS; i++)
               check("addr_start", 64'(dut_addr(i)), 64'(model_addr(i, e_tile[c])));
         end
         if (clear_cyc >= 0 && c == clear_cyc + 1) begin
            check("iter_clear", 64'(iter_idx_o), 64'd0);
            for (int i = 0; i < NS; i++)
               check("addr_clear", 64'(dut_addr(i)), 64'd0);
         end
         if (clear_cyc < 0 && c == term)
            check("iter_last", 64'(iter_idx_o), 64'(eff - 1));
         if (clear_cyc < 0 && c == len - 1) begin
            for (int i = 0; i < NS; i++)
               check("addr_hold", 64'(dut_addr(i)), 64'(model_addr(i, eff)));
         end
         @(posedge clk);
         #1;
      end
      start_i = 0; clear_i = 0;
      src_done_i = '0; sink_done_i = '0; engine_done_i = 0;
   endtask

   task automatic rand_streams();
      for (int i = 0; i < NS; i++) begin
         bases[i]   = $urandom;
         strides[i] = SW'($urandom_range(0, 65535));
      end
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation time limit reached");
      $fatal(1, "time limit");
   end

   initial begin
      rst_n = 0; clear_i = 0; start_i = 0; nb_iter_i = '0;
      base_addr_i = '0; tile_stride_i = '0;
      src_done_i = '0; sink_done_i = '0; engine_done_i = 0;
      repeat (3) @(posedge clk);
      @(negedge clk) rst_n = 1;
      @(posedge clk);
      #1;
      check("rst_busy", 64'(busy_o), 64'd0);
      check("rst_done", 64'(done_o), 64'd0);
      check("rst_req", 64'({src_req_o, sink_req_o, engine_start_o}), 64'd0);
      check("rst_iter", 64'(iter_idx_o), 64'd0);
      check("rst_addr", 64'(stream_addr_o), 64'd0);

      rand_streams();
      run_job(1, 1, -1, 0);

      for (int i = 0; i < NS; i++) begin
         bases[i] = 32'h0000_1000; strides[i] = 16'h0040;
      end
      run_job(4, 1, -1, 0);

      rand_streams();
      run_job(2, 2, -1, 0);

      for (int i = 0; i < NS; i++) begin
         bases[i] = 32'hFFFF_FFC0; strides[i] = 16'h0080;
      end
      run_job(2, 1, -1, 0);

      rand_streams();
      run_job(3, 0, 1, 0);
      run_job(2, 0, -1, 0);

      run_job(0, 1, -1, 0);

      for (int n = 0; n < 10; n++) begin
         rand_streams();
         run_job(int'($urandom_range(0, 5)), 0, -1, 0);
      end

`ifndef HWPE_DATAFLOW_FSM_WATCHDOG_EN
      rand_streams();
      run_job(1, 1, -1, 1);
`endif

      rand_streams();
      for (int i = 0; i < NS; i++) base_addr_i[i*AW +: AW] = bases[i] | 32'h1;
      nb_iter_i = 16'd3;
      start_i = 1;
      @(posedge clk); #1;
      start_i = 0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("mid_busy", 64'(busy_o), 64'd1);
      #2 rst_n = 0;
      #1;
      check("arst_busy", 64'(busy_o), 64'd0);
      check("arst_req", 64'({src_req_o, sink_req_o, engine_start_o}), 64'd0);
      check("arst_addr", 64'(stream_addr_o), 64'd0);
      check("arst_iter", 64'(iter_idx_o), 64'd0);
      @(negedge clk) rst_n = 1;
      @(posedge clk); #1;
      check("post_rst_busy", 64'(busy_o), 64'd0);
      check("post_rst_done", 64'(done_o), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
